// File: rtl/imem_program_loader_if.sv
// Byte stream and instruction-memory write bus for the program loader.
// The slave modport is the loader's view; master is the stream source / memory side.
interface imem_program_loader_if;
  logic [7:0]  Byte_In;
  logic        Byte_Valid;
  logic        Byte_Ready;
  logic        Wr_En;
  logic [15:0] Wr_Adr;
  logic [31:0] Wr_Data;

  modport master (
    output Byte_In, Byte_Valid,
    input  Byte_Ready, Wr_En, Wr_Adr, Wr_Data
  );

  modport slave (
    input  Byte_In, Byte_Valid,
    output Byte_Ready, Wr_En, Wr_Adr, Wr_Data
  );
endinterface

// File: rtl/imem_program_loader.sv
// Instruction memory program loader: takes a 16-bit word count header followed
// by big-endian 32-bit words from a byte stream, writes them to consecutive
// even addresses and keeps the CPU core in reset until the load completes.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | after reset, waiting for Start; core held
// HDR_HI   | receiving word count bits 15:8
// HDR_LO   | receiving word count bits 7:0, then range check
// DATA     | receiving the four bytes of the current word
// WRITE    | one-cycle memory write strobe for the assembled word
// DONE     | program loaded, core released
// ERR      | header rejected; core held, stream stalled
module imem_program_loader #(
  parameter logic [15:0] BASE_ADR  = 16'h0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic                        Clock_Puls,
  input  logic                        Reset,
  input  logic                        Start,
  imem_program_loader_if.slave        bus,
  output logic                        CPU_Hold,
  output logic                        Done,
  output logic                        Error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [15:0] MAX_W16 = 16'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [7:0]  count_hi_q;
  logic [15:0] remaining_q;
  logic [1:0]  byte_idx_q;
  logic [23:0] shift_q;
  logic [15:0] wr_adr_q;
  logic [31:0] wr_data_q;

  logic        xfer;
  logic        restart;
  logic [15:0] hdr_count;

  assign bus.Byte_Ready = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) || (state_q == S_DATA);
  assign bus.Wr_En      = (state_q == S_WRITE);
  assign bus.Wr_Adr     = wr_adr_q;
  assign bus.Wr_Data    = wr_data_q;
  assign CPU_Hold       = (state_q != S_DONE);
  assign Done           = (state_q == S_DONE);
  assign Error          = (state_q == S_ERR);

  assign xfer      = bus.Byte_Valid && bus.Byte_Ready;
  assign restart   = Start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign hdr_count = {count_hi_q, bus.Byte_In};

  // State register.
  always_ff @(posedge Clock_Puls or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (Start) state_d = S_HDR_HI;
      S_HDR_HI:              if (xfer) state_d = S_HDR_LO;
      S_HDR_LO: begin
        if (xfer) begin
          if ((hdr_count == 16'd0) || (hdr_count > MAX_W16)) state_d = S_ERR;
          else                                                state_d = S_DATA;
        end
      end
      S_DATA:                if (xfer && (byte_idx_q == 2'd3)) state_d = S_WRITE;
      // remaining still counts the word being written here
      S_WRITE:               state_d = (remaining_q == 16'd1) ? S_DONE : S_DATA;
      default:               state_d = S_IDLE;
    endcase
  end

  // Header capture, word assembly, write address and word count bookkeeping.
  always_ff @(posedge Clock_Puls or posedge Reset) begin
    if (Reset) begin
      count_hi_q  <= 8'h00;
      remaining_q <= 16'h0000;
      byte_idx_q  <= 2'd0;
      shift_q     <= 24'h000000;
      wr_adr_q    <= BASE_ADR;
      wr_data_q   <= 32'h0000_0000;
    end else begin
      if (restart) begin
        wr_adr_q   <= BASE_ADR;
        byte_idx_q <= 2'd0;
      end
      if ((state_q == S_HDR_HI) && xfer) count_hi_q <= bus.Byte_In;
      if ((state_q == S_HDR_LO) && xfer) remaining_q <= hdr_count;
      if ((state_q == S_DATA) && xfer) begin
        shift_q    <= {shift_q[15:0], bus.Byte_In};
        byte_idx_q <= byte_idx_q + 2'd1;
        // word output only changes when a complete word is ready
        if (byte_idx_q == 2'd3) wr_data_q <= {shift_q, bus.Byte_In};
      end
      if (state_q == S_WRITE) begin
        wr_adr_q    <= wr_adr_q + 16'd2;
        remaining_q <= remaining_q - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Testbench for imem_program_loader: randomized and directed byte streams, a
// stream-level reference model that predicts every memory write, and an
// independent monitor that checks writes against the prediction queue.
module tb_imem_program_loader;

  localparam logic [15:0] BASE = 16'h0000;
  localparam int          MAX  = 256;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [15:0] adr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_hold, done, error;

  imem_program_loader_if bus ();

  imem_program_loader #(.BASE_ADR(BASE), .MAX_WORDS(MAX)) dut (
    .Clock_Puls (clk),
    .Reset      (rst),
    .Start      (start),
    .bus        (bus),
    .CPU_Hold   (cpu_hold),
    .Done       (done),
    .Error      (error)
  );

  always #5 clk = ~clk;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest predicted write.
  logic prev_wr = 1'b0;
  wr_t  mon_e;
  always @(negedge clk) begin
    if (rst) begin
      prev_wr = 1'b0;
    end else begin
      if (bus.Wr_En === 1'b1) begin
        check("ready_low_in_write", 64'(bus.Byte_Ready), 64'd0);
        check("wr_en_single_cycle", 64'(prev_wr), 64'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got adr %h data %h, expected no write", bus.Wr_Adr, bus.Wr_Data);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_adr", 64'(bus.Wr_Adr), 64'(mon_e.adr));
          check("wr_data", 64'(bus.Wr_Data), 64'(mon_e.data));
          check("wr_latency_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end
      prev_wr = bus.Wr_En;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte_ready"}, 64'(bus.Byte_Ready), 64'd0);
    check({tag, "_wr_en"},      64'(bus.Wr_En),      64'd0);
    check({tag, "_wr_adr"},     64'(bus.Wr_Adr),     64'(BASE));
    check({tag, "_wr_data"},    64'(bus.Wr_Data),    64'd0);
    check({tag, "_cpu_hold"},   64'(cpu_hold),       64'd1);
    check({tag, "_done"},       64'(done),           64'd0);
    check({tag, "_error"},      64'(error),          64'd0);
  endtask

  // Present one byte after 'gap' idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_start, output bit ok);
    ok = 1'b0;
    repeat (gap) begin
      bus.Byte_Valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.Byte_In    = b;
    bus.Byte_Valid = 1'b1;
    start          = pulse_start;
    for (int budget = 0; budget < 200; budget++) begin
      @(negedge clk);
      ok = bus.Byte_Ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (ok) break;
    end
    bus.Byte_Valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_accept_timeout: byte %h not accepted, expected acceptance within 200 cycles", b);
    end
  endtask

  // Start a load and feed a stream. mode 0: back-to-back, 1: one idle cycle
  // before each byte, 2: random gaps plus stray Start pulses mid-load.
  // stop_after >= 0 abandons the stream after that many bytes.
  task automatic run_stream(input bq_t s, input int mode, input bit start_with_byte, input int stop_after);
    logic [15:0] count;
    bit          hdr_ok;
    bit          acc;
    int          gap;
    bit          ps;
    int          w;
    count  = {s[0], s[1]};
    hdr_ok = (count != 16'd0) && (int'(count) <= MAX);

    start = 1'b1;
    if (start_with_byte) begin
      bus.Byte_In    = s[0];
      bus.Byte_Valid = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_after_start", 64'(cpu_hold), 64'd1);
    check("done_clear_after_start", 64'(done), 64'd0);
    check("error_clear_after_start", 64'(error), 64'd0);

    for (int i = 0; i < s.size(); i++) begin
      if ((stop_after >= 0) && (i == stop_after)) return;
      gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3));
      ps  = (mode == 2) && (i >= 1) && ($urandom_range(0, 5) == 0);
      send_byte(s[i], gap, ps, acc);
      if (!acc) return;
      if ((i >= 5) && (((i - 2) % 4) == 3)) begin
        w = (i - 2) / 4;
        exp_q.push_back('{adr: BASE + 16'(2 * w), data: {s[i-3], s[i-2], s[i-1], s[i]}, cyc: cyc});
      end
    end

    if (!hdr_ok) begin
      check("err_error", 64'(error), 64'd1);
      check("err_cpu_hold", 64'(cpu_hold), 64'd1);
      check("err_done", 64'(done), 64'd0);
      check("err_byte_ready", 64'(bus.Byte_Ready), 64'd0);
      bus.Byte_Valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.Byte_Valid = 1'b0;
      check("err_stays_error", 64'(error), 64'd1);
    end else begin
      @(posedge clk); #1;
      check("done_after_last_write", 64'(done), 64'd1);
      check("cpu_released", 64'(cpu_hold), 64'd0);
      check("no_error_on_good_load", 64'(error), 64'd0);
      check("all_writes_seen", 64'(exp_q.size()), 64'd0);
    end
  endtask

  function automatic bq_t make_stream(input logic [15:0] count, input int n_words);
    bq_t s;
    logic [15:0] c;
    c = count;
    s = {};
    s.push_back(c[15:8]);
    s.push_back(c[7:0]);
    for (int i = 0; i < 4 * n_words; i++) s.push_back(8'($urandom_range(0, 255)));
    return s;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t s;
    logic [15:0] c;
    rst            = 1'b1;
    start          = 1'b0;
    bus.Byte_In    = 8'h00;
    bus.Byte_Valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_reset_vals("idle_no_start");

    s = {8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_stream(s, 0, 1'b1, -1);
    run_stream(s, 1, 1'b0, -1);

    run_stream({8'h00, 8'h00}, 0, 1'b0, -1);
    run_stream({8'h01, 8'h01}, 1, 1'b0, -1);
    run_stream(make_stream(16'h0100, 256), 0, 1'b0, -1);

    // Reset after the second byte of the second word.
    run_stream(s, 0, 1'b0, 8);
    rst = 1'b1;
    #1;
    check_reset_vals("async_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("no_pending_after_reset", 64'(exp_q.size()), 64'd0);
    exp_q = {};
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("after_reset");
    run_stream({8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, 0, 1'b0, -1);

    check("done_before_restart_hold", 64'(cpu_hold), 64'd0);
    run_stream({8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44}, 2, 1'b0, -1);

    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0:       c = 16'h0000;
        1:       c = 16'(MAX + 1 + int'($urandom_range(0, 2000)));
        default: c = 16'($urandom_range(1, 6));
      endcase
      if ((c == 16'h0000) || (int'(c) > MAX)) s = make_stream(c, 0);
      else                                    s = make_stream(c, int'(c));
      run_stream(s, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1);
    end

    repeat (5) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
